drum_hit_recorder: RTL

Live-input pattern writer for the drum sequencer. It captures player hits on up to four instrument buttons against the BPM step tick. Each hit is quantized to the nearest step, and after one bar the block delivers the four 8-step patterns that the playback datapath reads. It sits between the BPM tick generator and the pattern-load path, as the recording counterpart of the switch-based pattern entry.

---
 rtl/drum_hit_recorder_if.sv | 16 +
 rtl/drum_hit_recorder.sv | 109 ++++++++++
 2 files changed

// File: rtl/drum_hit_recorder_if.sv
// drum_hit_recorder_if: tick, arm/abort, button inputs and status/pattern outputs of the hit recorder
interface drum_hit_recorder_if;
  logic step_tick, arm, abort;
  logic [3:0] hit;
  logic busy, counting_in, done;
  logic [2:0] step_idx;
  logic [7:0] ins1_pat, ins2_pat, ins3_pat, ins4_pat;
  modport master(
    output step_tick, arm, abort, hit,
    input busy, counting_in, done, step_idx, ins1_pat, ins2_pat, ins3_pat, ins4_pat
  );
  modport slave(
    input step_tick, arm, abort, hit,
    output busy, counting_in, done, step_idx, ins1_pat, ins2_pat, ins3_pat, ins4_pat
  );
endinterface

// File: rtl/drum_hit_recorder.sv
// drum_hit_recorder: records button hits quantized to the nearest step over one bar
module drum_hit_recorder #(
  parameter int STEPS = 8,
  parameter int CW = 27
) (
  input logic clk,
  input logic reset,
  drum_hit_recorder_if.slave bus
);
  localparam int SW = $clog2(STEPS);
  typedef enum logic [1:0] {IDLE, COUNT_IN, RECORD, DONE} state_t;
  state_t state;
  logic [3:0] hit_prev, hit_rise;
  logic [CW-1:0] cyc, period;
  logic pvalid, seen, late, wr;
  logic [SW-1:0] ci_cnt, idx;
  logic [3:0][STEPS-1:0] sh, sh_n;
  assign hit_rise = bus.hit & ~hit_prev;
  assign late = !bus.step_tick && pvalid && cyc >= (period >> 1);
  assign wr = state == RECORD || (state == COUNT_IN && ci_cnt == SW'(STEPS - 1) && late);
  // late hits and hits on the tick itself land on the following step, wrapping at the bar end
  assign idx = state == COUNT_IN ? '0 : (late || bus.step_tick) ? SW'(bus.step_idx + 1'b1) : bus.step_idx;
  always_comb begin
    sh_n = sh;
    for (int k = 0; k < 4; k++)
      if (wr && hit_rise[k]) sh_n[k][idx] = 1'b1;
  end
  always_ff @(posedge clk) begin
    hit_prev <= bus.hit;
    if (!reset) begin
      state <= IDLE;
      cyc <= '0;
      period <= '0;
      pvalid <= 1'b0;
      seen <= 1'b0;
      ci_cnt <= '0;
      sh <= '0;
      bus.busy <= 1'b0;
      bus.counting_in <= 1'b0;
      bus.step_idx <= '0;
      bus.done <= 1'b0;
      bus.ins1_pat <= '0;
      bus.ins2_pat <= '0;
      bus.ins3_pat <= '0;
      bus.ins4_pat <= '0;
    end else begin
      bus.done <= 1'b0;
      cyc <= bus.step_tick ? '0 : cyc + CW'(cyc != '1);
      sh <= sh_n;
      if (bus.step_tick) begin
        seen <= 1'b1;
        if (seen) begin
          period <= cyc + CW'(cyc != '1);
          pvalid <= 1'b1;
        end
      end
      case (state)
        IDLE: begin
          cyc <= '0;
          seen <= 1'b0;
          pvalid <= 1'b0;
          ci_cnt <= '0;
          sh <= '0;
          if (bus.arm && !bus.abort) begin
            state <= COUNT_IN;
            bus.busy <= 1'b1;
            bus.counting_in <= 1'b1;
          end
        end
        COUNT_IN: begin
          if (bus.abort) begin
            state <= IDLE;
            bus.busy <= 1'b0;
            bus.counting_in <= 1'b0;
          end else if (bus.step_tick) begin
            ci_cnt <= ci_cnt + 1'b1;
            if (ci_cnt == SW'(STEPS - 1)) begin
              state <= RECORD;
              bus.counting_in <= 1'b0;
              bus.step_idx <= '0;
            end
          end
        end
        RECORD: begin
          if (bus.abort) begin
            state <= IDLE;
            bus.busy <= 1'b0;
            bus.step_idx <= '0;
          end else if (bus.step_tick) begin
            if (bus.step_idx == SW'(STEPS - 1)) begin
              // publish includes any hit on the final tick itself
              state <= DONE;
              bus.step_idx <= '0;
              bus.done <= 1'b1;
              bus.ins1_pat <= sh_n[0];
              bus.ins2_pat <= sh_n[1];
              bus.ins3_pat <= sh_n[2];
              bus.ins4_pat <= sh_n[3];
            end else bus.step_idx <= bus.step_idx + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          bus.busy <= 1'b0;
        end
      endcase
    end
  end
endmodule
